game_lives_multi: RTL and testbench
===================================

# game_lives_multi

Parametrised lives and damage controller for up to NUM_PLAYERS bombermen, sitting between the pixel-overlap logic (hitbox vs. enemy/explosion) and the movement, bomb and arena-colour logic. Each player has an independent life counter, a timed invulnerability window with sprite blink, and extra-life pickups. The block produces per-player game-over flags, a global game-over flag and the arena background colour. It generalises the single-player, fixed-5-life tracker to N players, configurable life counts and timing, and adds pickups and blink.

## Interface
- NUM_PLAYERS, 2, number of independent player channels (1..4)
- LIVES_W, 3, width of each life counter
- START_LIVES, 5, lives loaded at reset (1..MAX_LIVES)
- MAX_LIVES, 7, saturation limit for pickups (≤ 2^LIVES_W−1)
- INVULN_CYCLES, 150000000, length of invulnerability window in clk cycles (≥ 2)
- BLINK_CYCLES, 6250000, half-period of sprite blink during invulnerability (≥ 1)
- clk  in  1  system clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- hb_on  in  NUM_PLAYERS  per-player hitbox-on-current-pixel
- enemy_on  in  1  enemy sprite on current pixel
- exp_on  in  1  explosion on current pixel
- pickup  in  NUM_PLAYERS  one-cycle extra-life pulse per player
- lives  out  NUM_PLAYERS*LIVES_W  packed life counts, player 0 in LSBs
- invuln  out  NUM_PLAYERS  player currently invulnerable
- sprite_en  out  NUM_PLAYERS  player sprite visible (blink gate)
- player_over  out  NUM_PLAYERS  player has 0 lives; freeze its movement and bombs
- gameover  out  1  all players have 0 lives
- background_rgb  out  12  arena colour {R,G,B} nibbles

## Operation
- Per player: hit_i = hb_on[i] & (enemy_on | exp_on), sampled every cycle.
- Per-player FSM, states ALIVE, INVULN, DEAD.
  - ALIVE, hit_i, lives>1: lives−1 (+1 if pickup[i] same cycle, net 0), load counter with INVULN_CYCLES−1, go INVULN.
  - ALIVE, hit_i, lives==1, no pickup: lives→0, go DEAD. With pickup same cycle: lives stays 1, go INVULN.
  - ALIVE, no hit: pickup increments lives saturating at MAX_LIVES.
  - INVULN: hit_i ignored; pickup increments (saturating); counter decrements each cycle; on counter==0 go ALIVE next cycle. Window is exactly INVULN_CYCLES cycles.
  - DEAD: absorbing until reset; hit and pickup ignored; lives held 0.
- Blink: separate per-player counter active only in INVULN; sprite_en toggles every BLINK_CYCLES cycles starting at 0 on INVULN entry; sprite_en=1 in ALIVE; sprite_en=0 in DEAD.
- invuln[i] = (state==INVULN); player_over[i] = (state==DEAD); gameover = AND of player_over.
- background_rgb: m = minimum lives over players not DEAD (m=0 if all DEAD); R nibble = m saturated to 15, G=B=0. All DEAD → 12'h000.
- Arithmetic: lives unsigned LIVES_W bits; no wrap in either direction; counters sized ceil(log2(INVULN_CYCLES)) and ceil(log2(BLINK_CYCLES)).

## Timing
- All outputs registered; hit or pickup at cycle t visible on lives/invuln/player_over at t+1; background_rgb and gameover at t+1 as well (combinational from registered state, no extra stage).
- Reset (reset_n=0 at a rising edge): all lives=START_LIVES, state ALIVE, counters 0, invuln=0, sprite_en=all 1, player_over=0, gameover=0, background_rgb={START_LIVES sat 15,8'h00}. Reset mid-window aborts invulnerability immediately.
- Simultaneous hits on several players same cycle: each decremented independently.
- Hit asserted for many consecutive cycles: exactly one life lost per window; if still asserted on the cycle ALIVE is re-entered, next life lost that cycle.
- Pickup and hit in INVULN same cycle: pickup only.

## Test plan
- Reset, NUM_PLAYERS=2, START_LIVES=3, INVULN_CYCLES=8, BLINK_CYCLES=2 -> lives=6'b011011, sprite_en=2'b11, background_rgb=12'h300, gameover=0.
- Hold hb_on[0]&exp_on for 20 cycles -> lives0 3→2 at t+1, invuln[0] high exactly 8 cycles, sprite_en[0] pattern 0,0,1,1,0,0,1,1, then lives0 2→1 on ALIVE re-entry; lives1 stays 3.
- Hit player 0 three times separated by 10 idle cycles -> player_over[0]=1, lives0=0, background_rgb=12'h300 (from player 1), gameover=0; further hits/pickups on player 0 ignored.
- Pickup[1] ×6 pulses from 3 with MAX_LIVES=7 -> lives1 4,5,6,7,7,7 (saturates).
- Player 0 lives=1, hit and pickup[0] same cycle -> lives0 stays 1, enters INVULN, not DEAD.
- Kill both players -> gameover=1, background_rgb=12'h000; assert reset_n=0 one cycle mid-window -> full reset values next cycle.

Source files
------------

// File: rtl/game_lives_multi.sv
// game_lives_multi: multi-player lives / damage controller.
// Each player channel tracks its own life count, a timed invulnerability
// window with sprite blink, and extra-life pickups. The top level derives the
// global game-over flag and the arena colour from the per-player state.

module game_lives_player #(
  parameter int LIVES_W       = 3,
  parameter int START_LIVES   = 5,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_CYCLES = 150000000,
  parameter int BLINK_CYCLES  = 6250000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hit,
  input  logic               pickup,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               sprite_en,
  output logic               dead
);
  // A 1-cycle blink period still needs a 1-bit counter.
  localparam int CW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [1:0] ALIVE  = 2'd0;
  localparam logic [1:0] INVULN = 2'd1;
  localparam logic [1:0] DEAD   = 2'd2;

  localparam logic [CW-1:0]      INV_LOAD  = CW'(INVULN_CYCLES - 1);
  localparam logic [CW-1:0]      INV_ONE   = CW'(1);
  localparam logic [BW-1:0]      BLK_LOAD  = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0]      BLK_ONE   = BW'(1);
  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] ONE       = LIVES_W'(1);

  logic [1:0]         state, state_nxt;
  logic [LIVES_W-1:0] lives_q, lives_nxt, lives_inc;
  logic [CW-1:0]      inv_cnt, inv_cnt_nxt;
  logic [BW-1:0]      blk_cnt, blk_cnt_nxt;
  logic               sprite, sprite_nxt;

  // Pickup adds a life but never past MAX_LIVES.
  assign lives_inc = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + ONE;

  // Next-state logic for the ALIVE / INVULN / DEAD machine and its counters.
  always_comb begin
    state_nxt   = state;
    lives_nxt   = lives_q;
    inv_cnt_nxt = inv_cnt;
    blk_cnt_nxt = blk_cnt;
    sprite_nxt  = sprite;
    case (state)
      ALIVE: begin
        sprite_nxt = 1'b1;
        if (hit) begin
          if (pickup || lives_q > ONE) begin
            // A same-cycle pickup cancels the lost life, even on the last one.
            lives_nxt   = pickup ? lives_q : lives_q - ONE;
            state_nxt   = INVULN;
            inv_cnt_nxt = INV_LOAD;
            blk_cnt_nxt = BLK_LOAD;
            sprite_nxt  = 1'b0;
          end else begin
            lives_nxt  = '0;
            state_nxt  = DEAD;
            sprite_nxt = 1'b0;
          end
        end else if (pickup) begin
          lives_nxt = lives_inc;
        end
      end
      INVULN: begin
        // Hits are ignored for the whole window; pickups still count.
        if (pickup) lives_nxt = lives_inc;
        if (inv_cnt == '0) begin
          state_nxt   = ALIVE;
          sprite_nxt  = 1'b1;
          blk_cnt_nxt = '0;
        end else begin
          inv_cnt_nxt = inv_cnt - INV_ONE;
          if (blk_cnt == '0) begin
            sprite_nxt  = ~sprite;
            blk_cnt_nxt = BLK_LOAD;
          end else begin
            blk_cnt_nxt = blk_cnt - BLK_ONE;
          end
        end
      end
      default: begin
        // DEAD (and the unused encoding) is absorbing until reset.
        state_nxt   = DEAD;
        lives_nxt   = '0;
        sprite_nxt  = 1'b0;
        inv_cnt_nxt = '0;
        blk_cnt_nxt = '0;
      end
    endcase
  end

  // State and counter registers; reset also aborts any running window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ALIVE;
      lives_q <= LIVES_RST;
      inv_cnt <= '0;
      blk_cnt <= '0;
      sprite  <= 1'b1;
    end else begin
      state   <= state_nxt;
      lives_q <= lives_nxt;
      inv_cnt <= inv_cnt_nxt;
      blk_cnt <= blk_cnt_nxt;
      sprite  <= sprite_nxt;
    end
  end

  assign lives     = lives_q;
  assign invuln    = (state == INVULN);
  assign dead      = (state == DEAD);
  assign sprite_en = sprite;

endmodule

module game_lives_multi #(
  parameter int NUM_PLAYERS   = 2,
  parameter int LIVES_W       = 3,
  parameter int START_LIVES   = 5,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_CYCLES = 150000000,
  parameter int BLINK_CYCLES  = 6250000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PLAYERS-1:0]         hb_on,
  input  logic                           enemy_on,
  input  logic                           exp_on,
  input  logic [NUM_PLAYERS-1:0]         pickup,
  output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
  output logic [NUM_PLAYERS-1:0]         invuln,
  output logic [NUM_PLAYERS-1:0]         sprite_en,
  output logic [NUM_PLAYERS-1:0]         player_over,
  output logic                           gameover,
  output logic [11:0]                    background_rgb
);
  logic [NUM_PLAYERS-1:0][LIVES_W-1:0] lives_arr;
  logic [NUM_PLAYERS-1:0]              hit;
  logic [LIVES_W-1:0]                  min_lives;
  logic                                any_alive;
  logic [3:0]                          red;

  // A player is hit when its hitbox overlaps any enemy or explosion pixel.
  assign hit = hb_on & {NUM_PLAYERS{enemy_on | exp_on}};

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pl
    game_lives_player #(
      .LIVES_W      (LIVES_W),
      .START_LIVES  (START_LIVES),
      .MAX_LIVES    (MAX_LIVES),
      .INVULN_CYCLES(INVULN_CYCLES),
      .BLINK_CYCLES (BLINK_CYCLES)
    ) u_pl (
      .clk      (clk),
      .reset_n  (reset_n),
      .hit      (hit[g]),
      .pickup   (pickup[g]),
      .lives    (lives_arr[g]),
      .invuln   (invuln[g]),
      .sprite_en(sprite_en[g]),
      .dead     (player_over[g])
    );
  end

  // Packed array layout already puts player 0 in the LSBs.
  assign lives    = lives_arr;
  assign gameover = &player_over;

  // Lowest life count among players still in the game; 0 once all are out.
  always_comb begin
    min_lives = '0;
    any_alive = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!player_over[i] && (!any_alive || lives_arr[i] < min_lives)) begin
        min_lives = lives_arr[i];
        any_alive = 1'b1;
      end
    end
  end

  // Red intensity follows the weakest surviving player, clamped to a nibble.
  always_comb begin
    if (32'(min_lives) > 32'd15) red = 4'hF;
    else                         red = 4'(min_lives);
  end

  assign background_rgb = {red, 8'h00};

endmodule

// File: tb/tb_game_lives_multi.sv
// Scoreboard bench for game_lives_multi: a behavioural model predicts every
// output on each driven cycle; predictions are queued and compared after the
// clock edge, alongside directed checks of the documented scenarios.

module tb_game_lives_multi;
  localparam int NP = 2, LW = 3, SL = 3, ML = 7, IC = 8, BC = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NP-1:0]      hb_on = '0;
  logic               enemy_on = 1'b0;
  logic               exp_on = 1'b0;
  logic [NP-1:0]      pickup = '0;
  logic [NP*LW-1:0]   lives;
  logic [NP-1:0]      invuln, sprite_en, player_over;
  logic               gameover;
  logic [11:0]        background_rgb;

  always #5 clk = ~clk;

  game_lives_multi #(
    .NUM_PLAYERS(NP), .LIVES_W(LW), .START_LIVES(SL), .MAX_LIVES(ML),
    .INVULN_CYCLES(IC), .BLINK_CYCLES(BC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hb_on(hb_on), .enemy_on(enemy_on),
    .exp_on(exp_on), .pickup(pickup), .lives(lives), .invuln(invuln),
    .sprite_en(sprite_en), .player_over(player_over), .gameover(gameover),
    .background_rgb(background_rgb)
  );

  typedef struct packed {
    logic [NP*LW-1:0] lives;
    logic [NP-1:0]    inv;
    logic [NP-1:0]    spr;
    logic [NP-1:0]    over;
    logic             go;
    logic [11:0]      bg;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  // model: state 0=alive 1=invulnerable 2=dead; k = cycles elapsed in window
  int m_lives[NP];
  int m_st[NP];
  int m_k[NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model_step(input logic [NP-1:0] hb, input logic en, input logic ex,
                                     input logic [NP-1:0] pk, input logic rn);
    for (int p = 0; p < NP; p++) begin
      bit h;
      h = hb[p] && (en || ex);
      if (!rn) begin
        m_lives[p] = SL; m_st[p] = 0; m_k[p] = 0;
      end else if (m_st[p] == 0) begin
        if (h) begin
          if (pk[p]) begin m_st[p] = 1; m_k[p] = 0; end
          else if (m_lives[p] > 1) begin m_lives[p]--; m_st[p] = 1; m_k[p] = 0; end
          else begin m_lives[p] = 0; m_st[p] = 2; end
        end else if (pk[p]) begin
          m_lives[p] = (m_lives[p] + 1 > ML) ? ML : m_lives[p] + 1;
        end
      end else if (m_st[p] == 1) begin
        if (pk[p]) m_lives[p] = (m_lives[p] + 1 > ML) ? ML : m_lives[p] + 1;
        if (m_k[p] == IC - 1) m_st[p] = 0;
        else m_k[p]++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   mn;
    bit   found;
    e = '0; mn = 0; found = 0;
    for (int p = 0; p < NP; p++) begin
      e.lives[p*LW +: LW] = LW'(m_lives[p]);
      e.inv[p]  = (m_st[p] == 1);
      e.over[p] = (m_st[p] == 2);
      e.spr[p]  = (m_st[p] == 0) ? 1'b1 : (m_st[p] == 2) ? 1'b0 : (((m_k[p] / BC) % 2) == 1);
      if (m_st[p] != 2 && (!found || m_lives[p] < mn)) begin mn = m_lives[p]; found = 1; end
    end
    e.go = &e.over;
    e.bg = {4'((mn > 15) ? 15 : mn), 8'h00};
    return e;
  endfunction

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic step(input logic [NP-1:0] hb, input logic en, input logic ex,
                      input logic [NP-1:0] pk, input logic rn);
    exp_t e;
    hb_on = hb; enemy_on = en; exp_on = ex; pickup = pk; reset_n = rn;
    model_step(hb, en, ex, pk, rn);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("lives",    32'(lives),          32'(e.lives));
      chk("invuln",   32'(invuln),         32'(e.inv));
      chk("sprite",   32'(sprite_en),      32'(e.spr));
      chk("over",     32'(player_over),    32'(e.over));
      chk("gameover", 32'(gameover),       32'(e.go));
      chk("bg",       32'(background_rgb), 32'(e.bg));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic rst();
    step('0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    int         inv_cnt;

    // reset values
    rst(); rst();
    chk("rst_lives", 32'(lives), 32'b011011);
    chk("rst_spr",   32'(sprite_en), 32'b11);
    chk("rst_bg",    32'(background_rgb), 32'h300);
    chk("rst_go",    32'(gameover), 32'd0);

    // held explosion hit on player 0: one life per window, blink pattern
    pat = '0; inv_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(2'b01, 1'b0, 1'b1, '0, 1'b1);
      if (j == 0) chk("hold_first", 32'(lives[LW-1:0]), 32'd2);
      if (j < 8) pat[j] = sprite_en[0];
      if (j <= 8 && invuln[0]) inv_cnt++;
      if (j == 9) chk("hold_reentry", 32'(lives[LW-1:0]), 32'd1);
    end
    chk("hold_blink", 32'(pat), 32'hCC);
    chk("hold_window", 32'(inv_cnt), 32'd8);
    chk("hold_p1", 32'(lives[2*LW-1:LW]), 32'd3);
    idle(3);

    // three separated hits kill player 0; it then ignores hits and pickups
    rst();
    for (int n = 0; n < 3; n++) begin
      step(2'b01, 1'b1, 1'b0, '0, 1'b1);
      idle(10);
    end
    chk("dead_over", 32'(player_over[0]), 32'd1);
    chk("dead_lives", 32'(lives[LW-1:0]), 32'd0);
    chk("dead_bg", 32'(background_rgb), 32'h300);
    chk("dead_go", 32'(gameover), 32'd0);
    step(2'b01, 1'b1, 1'b1, 2'b01, 1'b1);
    step('0, 1'b0, 1'b0, 2'b01, 1'b1);
    chk("dead_ign", 32'(lives[LW-1:0]), 32'd0);

    // pickups on player 1 saturate at MAX_LIVES
    for (int n = 0; n < 6; n++) begin
      step('0, 1'b0, 1'b0, 2'b10, 1'b1);
      chk("pick_sat", 32'(lives[2*LW-1:LW]), 32'((SL + n + 1 > ML) ? ML : SL + n + 1));
      idle(1);
    end

    // last life plus same-cycle pickup survives into a window
    rst();
    step(2'b01, 1'b1, 1'b0, '0, 1'b1); idle(9);
    step(2'b01, 1'b1, 1'b0, '0, 1'b1); idle(9);
    step(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
    chk("save_lives", 32'(lives[LW-1:0]), 32'd1);
    chk("save_inv", 32'(invuln[0]), 32'd1);
    chk("save_over", 32'(player_over[0]), 32'd0);
    idle(9);

    // kill both players, then reset mid-window
    step(2'b01, 1'b0, 1'b1, '0, 1'b1); idle(2);
    for (int n = 0; n < 3; n++) begin
      step(2'b10, 1'b0, 1'b1, '0, 1'b1);
      idle(9);
    end
    chk("all_go", 32'(gameover), 32'd1);
    chk("all_bg", 32'(background_rgb), 32'h000);
    rst();
    step(2'b11, 1'b1, 1'b0, '0, 1'b1); idle(3);
    chk("mid_inv", 32'(invuln), 32'b11);
    rst();
    chk("mid_lives", 32'(lives), 32'b011011);
    chk("mid_inv0", 32'(invuln), 32'd0);
    chk("mid_spr", 32'(sprite_en), 32'b11);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(NP'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0), NP'($urandom_range(0, 7) == 0 ? 3 : 0),
           1'($urandom_range(0, 79) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
